// File: rtl/wb_arbiter_mp.sv
// Multi-source, multi-port register write-back arbiter: per-source FIFOs with bypass feed statically mapped regfile write ports.
// Optional WB_RR_ARB_EN selects per-port round-robin arbitration instead of fixed lowest-index priority.
module wb_arbiter_mp #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_PORT   = 2,
  parameter logic [NUM_SRC*((NUM_PORT > 1) ? $clog2(NUM_PORT) : 1)-1:0] SRC_PORT_MAP = 4'b1100,
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int CID_W      = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_valid_i,
  output logic [NUM_SRC-1:0]         src_ready_o,
  input  logic [NUM_SRC*DATA_W-1:0]  src_wdata_i,
  input  logic [NUM_SRC*ADDR_W-1:0]  src_waddr_i,
  input  logic [NUM_SRC*CID_W-1:0]   src_cid_i,
  output logic [NUM_PORT-1:0]        wb_we_o,
  output logic [NUM_PORT*ADDR_W-1:0] wb_waddr_o,
  output logic [NUM_PORT*DATA_W-1:0] wb_wdata_o,
  output logic [NUM_PORT-1:0]        commit_valid_o,
  output logic [NUM_PORT*CID_W-1:0]  commit_id_o
);
  localparam int PW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [CID_W-1:0]  cid;
  } entry_t;

  function automatic logic mapped(int s, int p);
    return int'(SRC_PORT_MAP[s*PW +: PW]) == p;
  endfunction

  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] ptr);
    return (ptr == AW'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  entry_t           mem_q    [NUM_SRC][FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr_q [NUM_SRC];
  logic [AW-1:0]    rd_ptr_d [NUM_SRC];
  logic [AW-1:0]    wr_ptr_q [NUM_SRC];
  logic [AW-1:0]    wr_ptr_d [NUM_SRC];
  logic [CW-1:0]    cnt_q    [NUM_SRC];
  logic [CW-1:0]    cnt_d    [NUM_SRC];
  entry_t           in_e     [NUM_SRC];
  entry_t           head     [NUM_SRC];
  logic [NUM_SRC-1:0]  full, empty, acc, req, grant, push, pop;
  logic [NUM_PORT-1:0] grant_any;

  logic [NUM_PORT-1:0]        wb_we_q, wb_we_d, commit_valid_q, commit_valid_d;
  logic [NUM_PORT*ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
  logic [NUM_PORT*DATA_W-1:0] wb_wdata_q, wb_wdata_d;
  logic [NUM_PORT*CID_W-1:0]  commit_id_q, commit_id_d;

  // Head of each source: FIFO entry when queued, otherwise the live input (bypass).
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      in_e[s]  = '{data: src_wdata_i[s*DATA_W +: DATA_W],
                   addr: src_waddr_i[s*ADDR_W +: ADDR_W],
                   cid:  src_cid_i[s*CID_W +: CID_W]};
      full[s]  = (cnt_q[s] == CW'(FIFO_DEPTH));
      empty[s] = (cnt_q[s] == '0);
      acc[s]   = src_valid_i[s] & ~full[s];
      req[s]   = ~empty[s] | acc[s];
      head[s]  = empty[s] ? in_e[s] : mem_q[s][rd_ptr_q[s]];
    end
  end

  assign src_ready_o = ~full;

`ifdef WB_RR_ARB_EN
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [SW-1:0] rr_ptr_q [NUM_PORT];
  logic [SW-1:0] rr_ptr_d [NUM_PORT];

  function automatic logic [SW-1:0] rr_init(int p);
    logic [SW-1:0] h;
    h = '0;
    for (int s = 0; s < NUM_SRC; s++) if (mapped(s, p)) h = SW'(s);
    return h;
  endfunction

  // Sources above the pointer are searched first, then the wrap-around range.
  always_comb begin
    int hi, lo, win;
    grant     = '0;
    grant_any = '0;
    rr_ptr_d  = rr_ptr_q;
    hi = -1; lo = -1; win = -1;
    for (int p = 0; p < NUM_PORT; p++) begin
      hi = -1;
      lo = -1;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (mapped(s, p) && req[s]) begin
          if (s > int'(rr_ptr_q[p])) begin
            if (hi < 0) hi = s;
          end else if (lo < 0) begin
            lo = s;
          end
        end
      end
      win = (hi >= 0) ? hi : lo;
      if (win >= 0) begin
        grant_any[p] = 1'b1;
        rr_ptr_d[p]  = SW'(win);
        for (int s = 0; s < NUM_SRC; s++) if (s == win) grant[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORT; p++) rr_ptr_q[p] <= rr_init(p);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_any = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (!grant_any[p] && mapped(s, p) && req[s]) begin
          grant[s]     = 1'b1;
          grant_any[p] = 1'b1;
        end
      end
    end
  end
`endif

  // A granted empty FIFO consumes its input by bypass; everything else accepted is queued.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      push[s]     = acc[s] & ~(grant[s] & empty[s]);
      pop[s]      = grant[s] & ~empty[s];
      wr_ptr_d[s] = push[s] ? ptr_inc(wr_ptr_q[s]) : wr_ptr_q[s];
      rd_ptr_d[s] = pop[s]  ? ptr_inc(rd_ptr_q[s]) : rd_ptr_q[s];
      cnt_d[s]    = cnt_q[s];
      if (push[s] && !pop[s])      cnt_d[s] = cnt_q[s] + 1'b1;
      else if (!push[s] && pop[s]) cnt_d[s] = cnt_q[s] - 1'b1;
    end
  end

  always_comb begin
    wb_waddr_d     = '0;
    wb_wdata_d     = '0;
    commit_id_d    = '0;
    wb_we_d        = '0;
    commit_valid_d = grant_any;
    for (int p = 0; p < NUM_PORT; p++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (mapped(s, p)) begin
          wb_waddr_d[p*ADDR_W +: ADDR_W] |= {ADDR_W{grant[s]}} & head[s].addr;
          wb_wdata_d[p*DATA_W +: DATA_W] |= {DATA_W{grant[s]}} & head[s].data;
          commit_id_d[p*CID_W +: CID_W]  |= {CID_W{grant[s]}}  & head[s].cid;
        end
      end
      wb_we_d[p] = grant_any[p] & (wb_waddr_d[p*ADDR_W +: ADDR_W] != '0);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      wb_we_q        <= '0;
      wb_waddr_q     <= '0;
      wb_wdata_q     <= '0;
      commit_valid_q <= '0;
      commit_id_q    <= '0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      cnt_q          <= cnt_d;
      wb_we_q        <= wb_we_d;
      wb_waddr_q     <= wb_waddr_d;
      wb_wdata_q     <= wb_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
    end
  end

  // NOTE: FIFO storage has no reset; counts gate every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push[s]) mem_q[s][wr_ptr_q[s]] <= in_e[s];
    end
  end

  assign wb_we_o        = wb_we_q;
  assign wb_waddr_o     = wb_waddr_q;
  assign wb_wdata_o     = wb_wdata_q;
  assign commit_valid_o = commit_valid_q;
  assign commit_id_o    = commit_id_q;

endmodule

// File: tb/tb_wb_arbiter_mp.sv
// Self-checking bench for wb_arbiter_mp: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_arbiter_mp;
  localparam int NS = 4, NP = 2, D = 2, DW = 32, AW = 5, CW = 3;
  localparam logic [3:0] MAP = 4'b1100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NS-1:0]    src_valid_i = '0;
  logic [NS-1:0]    src_ready_o;
  logic [NS*DW-1:0] src_wdata_i = '0;
  logic [NS*AW-1:0] src_waddr_i = '0;
  logic [NS*CW-1:0] src_cid_i = '0;
  logic [NP-1:0]    wb_we_o, commit_valid_o;
  logic [NP*AW-1:0] wb_waddr_o;
  logic [NP*DW-1:0] wb_wdata_o;
  logic [NP*CW-1:0] commit_id_o;

  always #5 clk = ~clk;

  wb_arbiter_mp #(
    .NUM_SRC(NS), .NUM_PORT(NP), .SRC_PORT_MAP(MAP), .FIFO_DEPTH(D),
    .DATA_W(DW), .ADDR_W(AW), .CID_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_wdata_i(src_wdata_i), .src_waddr_i(src_waddr_i), .src_cid_i(src_cid_i),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [CW-1:0] c;
  } ent_t;

  ent_t q[NS][$];
  int   rr_last[NP];
  logic [NP-1:0]    exp_we, exp_cv;
  logic [NP*AW-1:0] exp_waddr;
  logic [NP*DW-1:0] exp_wdata;
  logic [NP*CW-1:0] exp_cid;
  int errors = 0;
  int checks = 0;

  function automatic int port_of(int s);
    return int'(MAP[s]);
  endfunction

  function automatic logic [NS-1:0] exp_ready();
    logic [NS-1:0] r;
    for (int s = 0; s < NS; s++) r[s] = (q[s].size() < D);
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) q[s].delete();
    for (int p = 0; p < NP; p++) begin
      rr_last[p] = 0;
      for (int s = 0; s < NS; s++) if (port_of(s) == p) rr_last[p] = s;
    end
    exp_we = '0; exp_cv = '0; exp_waddr = '0; exp_wdata = '0; exp_cid = '0;
  endtask

  // One clock of the spec's rules: accept, pick a winner per port, pop/bypass, queue the rest.
  task automatic model_eval();
    logic acc[NS];
    logic granted[NS];
    int win;
    ent_t in_e, out_e;
    for (int s = 0; s < NS; s++) begin
      acc[s] = src_valid_i[s] && (q[s].size() < D);
      granted[s] = 1'b0;
    end
    exp_we = '0; exp_cv = '0; exp_waddr = '0; exp_wdata = '0; exp_cid = '0;
    for (int p = 0; p < NP; p++) begin
      win = -1;
`ifdef WB_RR_ARB_EN
      for (int k = 1; k <= NS; k++) begin
        int s;
        s = (rr_last[p] + k) % NS;
        if (win < 0 && port_of(s) == p && (q[s].size() > 0 || acc[s])) win = s;
      end
      if (win >= 0) rr_last[p] = win;
`else
      for (int s = 0; s < NS; s++)
        if (win < 0 && port_of(s) == p && (q[s].size() > 0 || acc[s])) win = s;
`endif
      if (win >= 0) begin
        granted[win] = 1'b1;
        in_e.d = src_wdata_i[win*DW +: DW];
        in_e.a = src_waddr_i[win*AW +: AW];
        in_e.c = src_cid_i[win*CW +: CW];
        if (q[win].size() > 0) begin
          out_e = q[win].pop_front();
          if (acc[win]) q[win].push_back(in_e);
        end else begin
          out_e = in_e;
        end
        exp_cv[p] = 1'b1;
        exp_we[p] = (out_e.a != 0);
        exp_waddr[p*AW +: AW] = out_e.a;
        exp_wdata[p*DW +: DW] = out_e.d;
        exp_cid[p*CW +: CW]   = out_e.c;
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (acc[s] && !granted[s]) begin
        in_e.d = src_wdata_i[s*DW +: DW];
        in_e.a = src_waddr_i[s*AW +: AW];
        in_e.c = src_cid_i[s*CW +: CW];
        q[s].push_back(in_e);
      end
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(string tag);
    checks++;
    if (src_ready_o !== exp_ready()) begin
      errors++;
      $display("FAIL %s ready: got %b want %b", tag, src_ready_o, exp_ready());
    end
    model_eval();
    @(posedge clk);
    #1;
    checks++;
    if (wb_we_o !== exp_we) begin
      errors++; $display("FAIL %s we: got %b want %b", tag, wb_we_o, exp_we);
    end
    checks++;
    if (commit_valid_o !== exp_cv) begin
      errors++; $display("FAIL %s commit_valid: got %b want %b", tag, commit_valid_o, exp_cv);
    end
    checks++;
    if (wb_waddr_o !== exp_waddr) begin
      errors++; $display("FAIL %s waddr: got %h want %h", tag, wb_waddr_o, exp_waddr);
    end
    checks++;
    if (wb_wdata_o !== exp_wdata) begin
      errors++; $display("FAIL %s wdata: got %h want %h", tag, wb_wdata_o, exp_wdata);
    end
    checks++;
    if (commit_id_o !== exp_cid) begin
      errors++; $display("FAIL %s commit_id: got %h want %h", tag, commit_id_o, exp_cid);
    end
    @(negedge clk);
  endtask

  task automatic set_src(int s, logic v, logic [AW-1:0] a, logic [DW-1:0] d, logic [CW-1:0] c);
    src_valid_i[s]        = v;
    src_waddr_i[s*AW +: AW] = a;
    src_wdata_i[s*DW +: DW] = d;
    src_cid_i[s*CW +: CW]   = c;
  endtask

  task automatic clr_inputs();
    src_valid_i = '0; src_waddr_i = '0; src_wdata_i = '0; src_cid_i = '0;
  endtask

  task automatic check_idle_outputs(string tag);
    checks++;
    if ({wb_we_o, commit_valid_o, wb_waddr_o, wb_wdata_o, commit_id_o} !== '0) begin
      errors++;
      $display("FAIL %s outputs: got we=%b cv=%b addr=%h data=%h id=%h want all 0",
               tag, wb_we_o, commit_valid_o, wb_waddr_o, wb_wdata_o, commit_id_o);
    end
    checks++;
    if (src_ready_o !== 4'hF) begin
      errors++; $display("FAIL %s ready: got %b want 1111", tag, src_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step("reset_idle");
  endtask

  task automatic test_single_bypass();
    clr_inputs();
    set_src(0, 1'b1, 5'd5, 32'hA5A5_0001, 3'd2);
    step("bypass");
    checks++;
    if ({wb_we_o[0], wb_waddr_o[4:0], wb_wdata_o[31:0], commit_id_o[2:0]} !== {1'b1, 5'd5, 32'hA5A5_0001, 3'd2}) begin
      errors++;
      $display("FAIL bypass_fields: got we=%b a=%0d d=%h id=%0d want we=1 a=5 d=a5a50001 id=2",
               wb_we_o[0], wb_waddr_o[4:0], wb_wdata_o[31:0], commit_id_o[2:0]);
    end
    clr_inputs();
    step("bypass_after");
    checks++;
    if (commit_valid_o !== 2'b00) begin
      errors++; $display("FAIL bypass_nothing_queued: got cv=%b want 00", commit_valid_o);
    end
  endtask

  task automatic test_collision();
    clr_inputs();
    set_src(0, 1'b1, 5'd7, 32'h1111_0000, 3'd1);
    set_src(1, 1'b1, 5'd8, 32'h2222_0000, 3'd2);
    step("collide1");
`ifndef WB_RR_ARB_EN
    checks++;
    if (commit_id_o[2:0] !== 3'd1) begin
      errors++; $display("FAIL collide_first: got id %0d want 1", commit_id_o[2:0]);
    end
`endif
    clr_inputs();
    step("collide2");
`ifndef WB_RR_ARB_EN
    checks++;
    if ({commit_valid_o[0], commit_id_o[2:0]} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL collide_second: got cv=%b id=%0d want cv=1 id=2", commit_valid_o[0], commit_id_o[2:0]);
    end
`endif
    step("collide_drain");
  endtask

  task automatic test_backpressure();
    clr_inputs();
    set_src(0, 1'b1, 5'd1, 32'hB000_0000, 3'd0);
    set_src(1, 1'b1, 5'd2, 32'hB100_0003, 3'd3);
    step("bp_c1");
    set_src(1, 1'b1, 5'd3, 32'hB100_0004, 3'd4);
    step("bp_c2");
    set_src(1, 1'b0, 5'd0, 32'h0, 3'd0);
`ifndef WB_RR_ARB_EN
    checks++;
    if (src_ready_o[1] !== 1'b0) begin
      errors++; $display("FAIL bp_full: got ready1=%b want 0", src_ready_o[1]);
    end
`endif
    step("bp_c3");
`ifndef WB_RR_ARB_EN
    checks++;
    if (commit_id_o[2:0] !== 3'd0) begin
      errors++; $display("FAIL bp_src0_wins: got id %0d want 0", commit_id_o[2:0]);
    end
`endif
    set_src(0, 1'b0, 5'd0, 32'h0, 3'd0);
    step("bp_c4");
`ifndef WB_RR_ARB_EN
    checks++;
    if ({src_ready_o[1], commit_id_o[2:0]} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL bp_drain1: got ready1=%b id=%0d want ready1=1 id=3", src_ready_o[1], commit_id_o[2:0]);
    end
`endif
    step("bp_c5");
`ifndef WB_RR_ARB_EN
    checks++;
    if (commit_id_o[2:0] !== 3'd4) begin
      errors++; $display("FAIL bp_drain2: got id %0d want 4", commit_id_o[2:0]);
    end
`endif
    for (int i = 0; i < 3; i++) step("bp_flush");
  endtask

  task automatic test_port_independence();
    clr_inputs();
    set_src(0, 1'b1, 5'd3, 32'hC000_0001, 3'd1);
    set_src(2, 1'b1, 5'd4, 32'hC200_0002, 3'd2);
    step("ports");
    checks++;
    if ({commit_valid_o, commit_id_o} !== {2'b11, 3'd2, 3'd1}) begin
      errors++; $display("FAIL ports_both: got cv=%b id=%h want cv=11 id=11", commit_valid_o, commit_id_o);
    end
    clr_inputs();
    step("ports_after");
    checks++;
    if (commit_valid_o !== 2'b00) begin
      errors++; $display("FAIL ports_no_push: got cv=%b want 00", commit_valid_o);
    end
  endtask

  task automatic test_x0_write();
    clr_inputs();
    set_src(3, 1'b1, 5'd0, 32'hDEAD_BEEF, 3'd6);
    step("x0");
    checks++;
    if ({wb_we_o[1], commit_valid_o[1], commit_id_o[5:3]} !== {1'b0, 1'b1, 3'd6}) begin
      errors++; $display("FAIL x0_fields: got we1=%b cv1=%b id1=%0d want we1=0 cv1=1 id1=6",
                         wb_we_o[1], commit_valid_o[1], commit_id_o[5:3]);
    end
    clr_inputs();
    step("x0_after");
  endtask

  task automatic test_reset_mid_burst();
    clr_inputs();
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < NS; s++) set_src(s, 1'b1, 5'(s + 1), 32'hE000_0000 + i, 3'(s));
      step("burst");
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle_outputs("reset_mid");
    @(negedge clk);
    clr_inputs();
    rst_n = 1'b1;
    step("reset_release");
    checks++;
    if (commit_valid_o !== 2'b00) begin
      errors++; $display("FAIL reset_queue_dropped: got cv=%b want 00", commit_valid_o);
    end
`ifdef WB_RR_ARB_EN
    begin
      logic [CW-1:0] seen[4];
      for (int i = 0; i < 4; i++) begin
        set_src(0, 1'b1, 5'd9, 32'hF000_0000, 3'd0);
        set_src(1, 1'b1, 5'd9, 32'hF100_0000, 3'd1);
        step("rr_alt");
        seen[i] = commit_id_o[2:0];
      end
      checks++;
      if ({seen[0], seen[1], seen[2], seen[3]} !== {3'd0, 3'd1, 3'd0, 3'd1}) begin
        errors++; $display("FAIL rr_alternate: got %0d %0d %0d %0d want 0 1 0 1", seen[0], seen[1], seen[2], seen[3]);
      end
      clr_inputs();
      for (int i = 0; i < 4; i++) step("rr_flush");
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < NS; s++) begin
        set_src(s, 1'($urandom_range(0, 99) < 60),
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                32'($urandom), 3'($urandom));
      end
      step("random");
    end
    clr_inputs();
    for (int i = 0; i < 4; i++) step("random_flush");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_bypass();
    test_collision();
    test_backpressure();
    test_port_independence();
    test_x0_write();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
